tsf_tbtt_scheduler: RTL and testbench

//  Owns the tsf_timer: arbitrates TSF load requests (software vs. hardware beacon sync) and

---
 rtl/tsf_tbtt_scheduler_pkg.sv | 33 +++
 rtl/tsf_tbtt_scheduler_load_seq.sv | 73 +++++++
 rtl/tsf_tbtt_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_tsf_tbtt_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsf_tbtt_scheduler_pkg.sv
// Shared definitions for the TSF load/TBTT scheduler: default widths,
// catch-up limit, FSM state encodings and a small state-class helper.
package tsf_tbtt_scheduler_pkg;

  localparam int unsigned TSF_TIMER_WIDTH_DEF    = 64;
  localparam int unsigned TSF_INTERVAL_WIDTH_DEF = 32;
  localparam int unsigned TSF_LEAD_WIDTH_DEF     = 16;
  localparam int unsigned TSF_CATCHUP_MAX_DEF    = 8;

  // Scheduler FSM (top)
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_CATCHUP   = 3'd2,
    ST_LOAD_SET  = 3'd3,
    ST_LOAD_CLR  = 3'd4,
    ST_LOAD_WAIT = 3'd5
  } sched_state_e;

  // Load sequencer FSM (sub-module), runs in lockstep with ST_LOAD_*
  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_SET  = 2'd1,
    SEQ_CLR  = 2'd2,
    SEQ_WAIT = 2'd3
  } load_seq_state_e;

  // States in which a pending TSF load request may be granted
  function automatic logic is_grant_state(input sched_state_e s);
    return (s == ST_IDLE) || (s == ST_ARMED) || (s == ST_CATCHUP);
  endfunction

endpackage

// File: rtl/tsf_tbtt_scheduler_load_seq.sv
// TSF load arbiter and sequencer.
// Fixed-priority 2-way arbiter (sw over hw) followed by a SET/CLR/WAIT
// sequence that pulses tsf_load_control for one cycle; tsf_timer loads on
// the falling edge, so the new TSF is visible two cycles after SET.
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   grant_en           scheduler is in a state that accepts a grant
//   sw_load_req/val    software load request (level) and value
//   sw_load_ack        1-cycle ack, issued in the CLR cycle
//   hw_load_req/val    hardware (beacon sync) load request and value
//   hw_load_ack        1-cycle ack, issued in the CLR cycle
//   tsf_load_control   load strobe to tsf_timer
//   tsf_load_val       load value to tsf_timer; holds until next grant
//   grant_c            combinational: a grant is taken this cycle
module tsf_tbtt_scheduler_load_seq
  import tsf_tbtt_scheduler_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH = TSF_TIMER_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   grant_en,
  input  logic                   sw_load_req,
  input  logic [TIMER_WIDTH-1:0] sw_load_val,
  output logic                   sw_load_ack,
  input  logic                   hw_load_req,
  input  logic [TIMER_WIDTH-1:0] hw_load_val,
  output logic                   hw_load_ack,
  output logic                   tsf_load_control,
  output logic [TIMER_WIDTH-1:0] tsf_load_val,
  output logic                   grant_c
);

  load_seq_state_e seq_state;
  logic            granted_sw;

  assign grant_c = grant_en && (seq_state == SEQ_IDLE) && (sw_load_req || hw_load_req);

  // Sequencer; acks and strobe are registered
  always_ff @(posedge clk) begin
    if (!rstn) begin
      seq_state        <= SEQ_IDLE;
      granted_sw       <= 1'b0;
      sw_load_ack      <= 1'b0;
      hw_load_ack      <= 1'b0;
      tsf_load_control <= 1'b0;
      tsf_load_val     <= '0;
    end else begin
      sw_load_ack <= 1'b0;
      hw_load_ack <= 1'b0;
      case (seq_state)
        SEQ_IDLE: begin
          if (grant_c) begin
            seq_state        <= SEQ_SET;
            granted_sw       <= sw_load_req;
            tsf_load_val     <= sw_load_req ? sw_load_val : hw_load_val;
            tsf_load_control <= 1'b1;
          end
        end
        SEQ_SET: begin
          seq_state        <= SEQ_CLR;
          tsf_load_control <= 1'b0;
          sw_load_ack      <= granted_sw;
          hw_load_ack      <= !granted_sw;
        end
        SEQ_CLR:  seq_state <= SEQ_WAIT;
        SEQ_WAIT: seq_state <= SEQ_IDLE;
        default:  seq_state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tsf_tbtt_scheduler.sv
// TSF owner and TBTT scheduler.
// Arbitrates TSF loads (via tsf_tbtt_scheduler_load_seq) and schedules
// periodic TBTT events from the running TSF: pre-TBTT warning, TBTT pulse,
// and missed-TBTT catch-up after TSF jumps, with forced realign after
// CATCHUP_MAX consecutive adds.
// Ports:
//   clk, rstn                        clock, synchronous active-low reset
//   enable                           0 -> IDLE and disarm (loads still granted)
//   arm, tbtt_first, beacon_interval start scheduling (interval 0 = one-shot)
//   pre_lead                         pre-TBTT lead in us (0 = no pre pulse)
//   sw_load_*/hw_load_*              TSF load request/value/ack pairs
//   tsf_runtime_val                  running TSF from tsf_timer
//   tsf_load_control, tsf_load_val   load interface to tsf_timer
//   tbtt_pulse, pre_tbtt_pulse       1-cycle event pulses
//   tbtt_missed                      1-cycle pulse, once per catch-up episode
//   next_tbtt                        current TBTT target
module tsf_tbtt_scheduler
  import tsf_tbtt_scheduler_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH    = TSF_TIMER_WIDTH_DEF,
  parameter int unsigned INTERVAL_WIDTH = TSF_INTERVAL_WIDTH_DEF,
  parameter int unsigned LEAD_WIDTH     = TSF_LEAD_WIDTH_DEF,
  parameter int unsigned CATCHUP_MAX    = TSF_CATCHUP_MAX_DEF
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      enable,
  input  logic                      arm,
  input  logic [TIMER_WIDTH-1:0]    tbtt_first,
  input  logic [INTERVAL_WIDTH-1:0] beacon_interval,
  input  logic [LEAD_WIDTH-1:0]     pre_lead,
  input  logic                      sw_load_req,
  input  logic [TIMER_WIDTH-1:0]    sw_load_val,
  output logic                      sw_load_ack,
  input  logic                      hw_load_req,
  input  logic [TIMER_WIDTH-1:0]    hw_load_val,
  output logic                      hw_load_ack,
  input  logic [TIMER_WIDTH-1:0]    tsf_runtime_val,
  output logic                      tsf_load_control,
  output logic [TIMER_WIDTH-1:0]    tsf_load_val,
  output logic                      tbtt_pulse,
  output logic                      pre_tbtt_pulse,
  output logic                      tbtt_missed,
  output logic [TIMER_WIDTH-1:0]    next_tbtt
);

  localparam int unsigned CNT_WIDTH = $clog2(CATCHUP_MAX + 1);

  sched_state_e           state;
  logic [TIMER_WIDTH-1:0] interval_q;
  logic [TIMER_WIDTH-1:0] pend_first;
  logic [TIMER_WIDTH-1:0] pend_interval;
  logic                   armed;
  logic                   arm_pend;
  logic                   pre_done;
  logic                   miss_sent;
  logic [CNT_WIDTH-1:0]   catchup_cnt;

  logic                   grant_c;
  logic                   interval_zero_c;
  logic                   pre_hit_c;
  logic [TIMER_WIDTH-1:0] next_plus_int_c;
  logic [TIMER_WIDTH-1:0] tsf_plus_int_c;
  logic [TIMER_WIDTH-1:0] tsf_plus_lead_c;

  // All adds are TIMER_WIDTH wide and wrap
  assign next_plus_int_c = next_tbtt + interval_q;
  assign tsf_plus_int_c  = tsf_runtime_val + interval_q;
  assign tsf_plus_lead_c = tsf_runtime_val + TIMER_WIDTH'(pre_lead);
  assign interval_zero_c = (interval_q == '0);
  assign pre_hit_c       = (pre_lead != '0) && !pre_done && (tsf_plus_lead_c >= next_tbtt);

  tsf_tbtt_scheduler_load_seq #(
    .TIMER_WIDTH (TIMER_WIDTH)
  ) u_load_seq (
    .clk              (clk),
    .rstn             (rstn),
    .grant_en         (is_grant_state(state)),
    .sw_load_req      (sw_load_req),
    .sw_load_val      (sw_load_val),
    .sw_load_ack      (sw_load_ack),
    .hw_load_req      (hw_load_req),
    .hw_load_val      (hw_load_val),
    .hw_load_ack      (hw_load_ack),
    .tsf_load_control (tsf_load_control),
    .tsf_load_val     (tsf_load_val),
    .grant_c          (grant_c)
  );

  // Scheduler FSM with registered event pulses
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      next_tbtt      <= '0;
      interval_q     <= '0;
      pend_first     <= '0;
      pend_interval  <= '0;
      armed          <= 1'b0;
      arm_pend       <= 1'b0;
      pre_done       <= 1'b0;
      miss_sent      <= 1'b0;
      catchup_cnt    <= '0;
      tbtt_pulse     <= 1'b0;
      pre_tbtt_pulse <= 1'b0;
      tbtt_missed    <= 1'b0;
    end else begin
      tbtt_pulse     <= 1'b0;
      pre_tbtt_pulse <= 1'b0;
      tbtt_missed    <= 1'b0;

      // Disable drops any schedule immediately; a load in flight still completes
      if (!enable) begin
        armed    <= 1'b0;
        arm_pend <= 1'b0;
      end

      case (state)
        ST_IDLE, ST_ARMED, ST_CATCHUP: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (arm) begin
            next_tbtt   <= tbtt_first;
            interval_q  <= TIMER_WIDTH'(beacon_interval);
            armed       <= 1'b1;
            pre_done    <= 1'b0;
            miss_sent   <= 1'b0;
            catchup_cnt <= '0;
            state       <= ST_CATCHUP;
          end else if (state == ST_ARMED) begin
            if (pre_hit_c) begin
              pre_tbtt_pulse <= 1'b1;
              pre_done       <= 1'b1;
            end
            if (tsf_runtime_val >= next_tbtt) begin
              if (interval_zero_c) begin
                tbtt_pulse <= 1'b1;
                armed      <= 1'b0;
                state      <= ST_IDLE;
              end else if (tsf_runtime_val < next_plus_int_c) begin
                tbtt_pulse <= 1'b1;
                next_tbtt  <= next_plus_int_c;
                pre_done   <= 1'b0;
              end else begin
                tbtt_missed <= 1'b1;
                miss_sent   <= 1'b1;
                catchup_cnt <= '0;
                state       <= ST_CATCHUP;
              end
            end
          end else if (state == ST_CATCHUP) begin
            if (next_tbtt > tsf_runtime_val) begin
              catchup_cnt <= '0;
              miss_sent   <= 1'b0;
              state       <= ST_ARMED;
            end else if (interval_zero_c) begin
              tbtt_missed <= 1'b1;
              armed       <= 1'b0;
              state       <= ST_IDLE;
            end else if (catchup_cnt == CNT_WIDTH'(CATCHUP_MAX)) begin
              // Too far behind: realign one interval past the current TSF
              next_tbtt   <= tsf_plus_int_c;
              catchup_cnt <= '0;
              miss_sent   <= 1'b0;
              pre_done    <= 1'b0;
              state       <= ST_ARMED;
            end else begin
              next_tbtt   <= next_plus_int_c;
              catchup_cnt <= catchup_cnt + CNT_WIDTH'(1);
              pre_done    <= 1'b0;
              // One missed report per catch-up episode
              if (!miss_sent) begin
                tbtt_missed <= 1'b1;
                miss_sent   <= 1'b1;
              end
            end
          end
          // A grant wins the next state after this cycle's event processing
          if (grant_c) state <= ST_LOAD_SET;
        end

        ST_LOAD_SET, ST_LOAD_CLR: begin
          if (enable && arm) begin
            arm_pend      <= 1'b1;
            pend_first    <= tbtt_first;
            pend_interval <= TIMER_WIDTH'(beacon_interval);
          end
          state <= (state == ST_LOAD_SET) ? ST_LOAD_CLR : ST_LOAD_WAIT;
        end

        ST_LOAD_WAIT: begin
          arm_pend    <= 1'b0;
          catchup_cnt <= '0;
          miss_sent   <= 1'b0;
          if (!enable) begin
            state <= ST_IDLE;
          end else if (arm || arm_pend) begin
            next_tbtt  <= arm ? tbtt_first : pend_first;
            interval_q <= arm ? TIMER_WIDTH'(beacon_interval) : pend_interval;
            armed      <= 1'b1;
            pre_done   <= 1'b0;
            state      <= ST_CATCHUP;
          end else if (armed) begin
            // TSF may have jumped: re-check the target against the new TSF
            state <= ST_CATCHUP;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tsf_tbtt_scheduler.sv
// Directed bench for tsf_tbtt_scheduler with a behavioural tsf_timer
// (increments 1 per clock, loads tsf_load_val on the falling edge of
// tsf_load_control).
module tb_tsf_tbtt_scheduler;

  localparam int unsigned TW = 64;
  localparam int unsigned IW = 32;
  localparam int unsigned LW = 16;

  localparam int SEL_TBTT  = 0;
  localparam int SEL_PRE   = 1;
  localparam int SEL_MISS  = 2;
  localparam int SEL_SWACK = 3;
  localparam int SEL_HWACK = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          enable;
  logic          arm;
  logic [TW-1:0] tbtt_first;
  logic [IW-1:0] beacon_interval;
  logic [LW-1:0] pre_lead;
  logic          sw_load_req;
  logic [TW-1:0] sw_load_val;
  logic          sw_load_ack;
  logic          hw_load_req;
  logic [TW-1:0] hw_load_val;
  logic          hw_load_ack;
  logic [TW-1:0] tsf;
  logic          tsf_load_control;
  logic [TW-1:0] tsf_load_val;
  logic          tbtt_pulse;
  logic          pre_tbtt_pulse;
  logic          tbtt_missed;
  logic [TW-1:0] next_tbtt;

  logic          ctrl_q;
  int            tests  = 0;
  int            failed = 0;
  int            tbtt_cnt = 0;
  int            pre_cnt  = 0;
  int            miss_cnt = 0;

  always #5 clk = ~clk;

  tsf_tbtt_scheduler dut (
    .clk              (clk),
    .rstn             (rstn),
    .enable           (enable),
    .arm              (arm),
    .tbtt_first       (tbtt_first),
    .beacon_interval  (beacon_interval),
    .pre_lead         (pre_lead),
    .sw_load_req      (sw_load_req),
    .sw_load_val      (sw_load_val),
    .sw_load_ack      (sw_load_ack),
    .hw_load_req      (hw_load_req),
    .hw_load_val      (hw_load_val),
    .hw_load_ack      (hw_load_ack),
    .tsf_runtime_val  (tsf),
    .tsf_load_control (tsf_load_control),
    .tsf_load_val     (tsf_load_val),
    .tbtt_pulse       (tbtt_pulse),
    .pre_tbtt_pulse   (pre_tbtt_pulse),
    .tbtt_missed      (tbtt_missed),
    .next_tbtt        (next_tbtt)
  );

  // Behavioural tsf_timer
  always @(posedge clk) begin
    if (!rstn) begin
      tsf    <= '0;
      ctrl_q <= 1'b0;
    end else begin
      ctrl_q <= tsf_load_control;
      if (ctrl_q && !tsf_load_control) tsf <= tsf_load_val;
      else                             tsf <= tsf + 64'd1;
    end
  end

  // Event counters, sampled mid-cycle
  always @(negedge clk) begin
    if (rstn) begin
      if (tbtt_pulse)     tbtt_cnt <= tbtt_cnt + 1;
      if (pre_tbtt_pulse) pre_cnt  <= pre_cnt + 1;
      if (tbtt_missed)    miss_cnt <= miss_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig_of(input int sel);
    case (sel)
      SEL_TBTT:  return tbtt_pulse;
      SEL_PRE:   return pre_tbtt_pulse;
      SEL_MISS:  return tbtt_missed;
      SEL_SWACK: return sw_load_ack;
      default:   return hw_load_ack;
    endcase
  endfunction

  // Tick until the selected signal is seen or the budget expires
  task automatic wait_for(input int sel, input int max_cycles, output logic found);
    found = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (sig_of(sel)) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Software load; returns in the first cycle the new TSF is visible
  task automatic do_sw_load(input logic [63:0] v, input string tag);
    logic f;
    sw_load_val = v;
    sw_load_req = 1'b1;
    wait_for(SEL_SWACK, 12, f);
    check({tag, "_ack"}, 64'(f), 64'd1);
    sw_load_req = 1'b0;
    tick();
    check({tag, "_tsf"}, tsf, v);
  endtask

  initial begin
    logic f;
    int   t0, m0, p0;

    rstn = 1'b0; enable = 1'b0; arm = 1'b0;
    tbtt_first = '0; beacon_interval = '0; pre_lead = '0;
    sw_load_req = 1'b0; sw_load_val = '0; hw_load_req = 1'b0; hw_load_val = '0;
    repeat (3) tick();

    // Reset state
    check("rst_tbtt",     64'(tbtt_pulse),       64'd0);
    check("rst_pre",      64'(pre_tbtt_pulse),   64'd0);
    check("rst_missed",   64'(tbtt_missed),      64'd0);
    check("rst_next",     next_tbtt,             64'd0);
    check("rst_ctrl",     64'(tsf_load_control), 64'd0);
    check("rst_load_val", tsf_load_val,          64'd0);
    check("rst_sw_ack",   64'(sw_load_ack),      64'd0);
    check("rst_hw_ack",   64'(hw_load_ack),      64'd0);
    rstn = 1'b1;
    tick();

    // 1: periodic schedule; pulses appear the cycle after the deciding TSF
    enable = 1'b1; pre_lead = 16'd10; tbtt_first = 64'd1000; beacon_interval = 32'd100;
    arm = 1'b1; tick(); arm = 1'b0;
    check("t1_next_arm", next_tbtt, 64'd1000);
    wait_for(SEL_PRE, 1200, f);
    check("t1_pre0_seen", 64'(f), 64'd1);
    check("t1_pre0_tsf", tsf - 64'd1, 64'd990);
    wait_for(SEL_TBTT, 50, f);
    check("t1_tbtt0_seen", 64'(f), 64'd1);
    check("t1_tbtt0_tsf", tsf - 64'd1, 64'd1000);
    check("t1_next1", next_tbtt, 64'd1100);
    wait_for(SEL_PRE, 150, f);
    check("t1_pre1_seen", 64'(f), 64'd1);
    check("t1_pre1_tsf", tsf - 64'd1, 64'd1090);
    wait_for(SEL_TBTT, 50, f);
    check("t1_tbtt1_tsf", tsf - 64'd1, 64'd1100);
    check("t1_next2", next_tbtt, 64'd1200);
    wait_for(SEL_TBTT, 150, f);
    check("t1_tbtt2_tsf", tsf - 64'd1, 64'd1200);
    check("t1_next3", next_tbtt, 64'd1300);

    // 2: simultaneous sw/hw requests, sw wins
    enable = 1'b0; tick();
    sw_load_val = 64'd5000; hw_load_val = 64'd7000;
    sw_load_req = 1'b1; hw_load_req = 1'b1;
    tick();
    check("t2_ctrl_set", 64'(tsf_load_control), 64'd1);
    check("t2_load_val_sw", tsf_load_val, 64'd5000);
    check("t2_sw_ack_early", 64'(sw_load_ack), 64'd0);
    tick();
    check("t2_ctrl_clr", 64'(tsf_load_control), 64'd0);
    check("t2_sw_ack", 64'(sw_load_ack), 64'd1);
    check("t2_hw_ack_not_yet", 64'(hw_load_ack), 64'd0);
    sw_load_req = 1'b0;
    tick();
    check("t2_tsf_sw", tsf, 64'd5000);
    check("t2_sw_ack_single", 64'(sw_load_ack), 64'd0);
    wait_for(SEL_HWACK, 8, f);
    check("t2_hw_ack_seen", 64'(f), 64'd1);
    check("t2_load_val_hw", tsf_load_val, 64'd7000);
    hw_load_req = 1'b0;
    tick();
    check("t2_tsf_hw", tsf, 64'd7000);

    // 3: load past the target -> one missed, 3 catch-up adds to 1400
    enable = 1'b1;
    do_sw_load(64'd1050, "t3_pre");
    tbtt_first = 64'd1100; beacon_interval = 32'd100;
    arm = 1'b1; tick(); arm = 1'b0;
    check("t3_next_arm", next_tbtt, 64'd1100);
    m0 = miss_cnt; t0 = tbtt_cnt;
    do_sw_load(64'd1350, "t3_load");
    wait_for(SEL_MISS, 6, f);
    check("t3_missed_seen", 64'(f), 64'd1);
    check("t3_next_add1", next_tbtt, 64'd1200);
    tick(); tick();
    check("t3_next_add3", next_tbtt, 64'd1400);
    check("t3_no_tbtt_catchup", 64'(tbtt_cnt - t0), 64'd0);
    wait_for(SEL_TBTT, 80, f);
    check("t3_tbtt_seen", 64'(f), 64'd1);
    check("t3_tbtt_tsf", tsf - 64'd1, 64'd1400);
    check("t3_missed_once", 64'(miss_cnt - m0), 64'd1);

    // 4: far jump -> CATCHUP_MAX adds, then realign to tsf+interval
    pre_lead = 16'd0; tbtt_first = 64'd1500; beacon_interval = 32'd10;
    arm = 1'b1; tick(); arm = 1'b0;
    check("t4_next_arm", next_tbtt, 64'd1500);
    p0 = pre_cnt; m0 = miss_cnt;
    do_sw_load(64'd20000, "t4_load");
    repeat (10) tick();
    check("t4_next_realign", next_tbtt, 64'd20019);
    wait_for(SEL_TBTT, 20, f);
    check("t4_tbtt_seen", 64'(f), 64'd1);
    check("t4_tbtt_tsf", tsf - 64'd1, 64'd20019);
    check("t4_no_pre", 64'(pre_cnt - p0), 64'd0);
    check("t4_missed_once", 64'(miss_cnt - m0), 64'd1);

    // 5: backward jump keeps target; one-shot; one-shot already in the past
    do_sw_load(64'd400, "t5_load");
    tick(); tick();
    check("t5_next_backjump", next_tbtt, 64'd20029);
    tbtt_first = 64'd500; beacon_interval = 32'd0;
    arm = 1'b1; tick(); arm = 1'b0;
    t0 = tbtt_cnt;
    wait_for(SEL_TBTT, 200, f);
    check("t5_tbtt_seen", 64'(f), 64'd1);
    check("t5_tbtt_tsf", tsf - 64'd1, 64'd500);
    repeat (30) tick();
    check("t5_oneshot_count", 64'(tbtt_cnt - t0), 64'd1);
    check("t5_next_hold", next_tbtt, 64'd500);
    m0 = miss_cnt;
    tbtt_first = 64'd100;
    arm = 1'b1; tick(); arm = 1'b0;
    wait_for(SEL_MISS, 4, f);
    check("t5_past_missed", 64'(f), 64'd1);
    t0 = tbtt_cnt;
    repeat (20) tick();
    check("t5_past_no_tbtt", 64'(tbtt_cnt - t0), 64'd0);
    check("t5_past_missed_once", 64'(miss_cnt - m0), 64'd1);

    // 6: disable during LOAD_CLR; then reset during LOAD_SET
    beacon_interval = 32'd20; tbtt_first = 64'd3050;
    arm = 1'b1; tick(); arm = 1'b0;
    t0 = tbtt_cnt;
    sw_load_val = 64'd3000; sw_load_req = 1'b1;
    wait_for(SEL_SWACK, 12, f);
    check("t6_ack_seen", 64'(f), 64'd1);
    enable = 1'b0; sw_load_req = 1'b0;
    tick();
    check("t6_tsf", tsf, 64'd3000);
    repeat (150) tick();
    check("t6_no_tbtt", 64'(tbtt_cnt - t0), 64'd0);

    enable = 1'b1; sw_load_val = 64'd9999; sw_load_req = 1'b1;
    tick();
    check("t6_rst_ctrl_before", 64'(tsf_load_control), 64'd1);
    rstn = 1'b0; sw_load_req = 1'b0;
    tick();
    check("t6_rst_ctrl", 64'(tsf_load_control), 64'd0);
    check("t6_rst_sw_ack", 64'(sw_load_ack), 64'd0);
    check("t6_rst_load_val", tsf_load_val, 64'd0);
    check("t6_rst_next", next_tbtt, 64'd0);
    tick();
    check("t6_rst_no_ack", 64'(sw_load_ack), 64'd0);
    rstn = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
